mxv_result_packer: RTL and testbench

Collects the scalar dot-product results streamed out of the matrix-vector multiply stage. Each result arrives with a one-cycle valid pulse, and the block packs `no_of_units` consecutive results into one wide AP word. It writes each completed word into the AP vector memory at an incrementing address and pulses `done` once `total` results have been stored. It sits directly downstream of the dot-product/MxV control stage and upstream of the AP memory.

---
 rtl/mxv_result_packer.sv | 120 ++++++++++++
 tb/tb_mxv_result_packer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_result_packer.sv
// Packs the scalar dot-product results of the MxV stage into wide AP memory words
// and writes them to consecutive AP word addresses, pulsing done at the end of a run.
module mxv_result_packer #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 10
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [31:0]                            total,
    input  logic [element_width-1:0]               result_in,
    input  logic                                   result_valid,
    output logic                                   mem_we,
    output logic [addr_width-1:0]                  mem_addr,
    output logic [element_width*no_of_units-1:0]   mem_wdata,
    output logic                                   busy,
    output logic                                   done,
    output logic [31:0]                            count
);

    localparam int word_width = element_width * no_of_units;
    localparam int lane_width = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam logic [lane_width-1:0] last_lane = lane_width'(no_of_units - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LAST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_r;
    logic [31:0]             total_r;
    logic [lane_width-1:0]   lane_r;
    logic [word_width-1:0]   buffer_r;
    logic [word_width-1:0]   merged_s;
    logic                    last_s;
    logic                    word_full_s;

    // Assembly buffer with the incoming result dropped into the current lane;
    // lanes above the current one are still zero because the buffer is cleared per word.
    always_comb begin
        merged_s = buffer_r;
        merged_s[lane_r*element_width +: element_width] = result_in;
        last_s      = ((count + 32'd1) == total_r);
        word_full_s = (lane_r == last_lane);
    end

    // Run control, assembly buffer, write pointer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            total_r   <= 32'd0;
            lane_r    <= '0;
            buffer_r  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // The pointer advances once the pending word has been presented.
            if (mem_we) begin
                mem_addr <= mem_addr + addr_width'(1);
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        total_r  <= total;
                        count    <= 32'd0;
                        lane_r   <= '0;
                        buffer_r <= '0;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        if (total == 32'd0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (result_valid) begin
                        count <= count + 32'd1;
                        if (word_full_s || last_s) begin
                            mem_wdata <= merged_s;
                            mem_we    <= 1'b1;
                            buffer_r  <= '0;
                            lane_r    <= '0;
                        end else begin
                            buffer_r  <= merged_s;
                            lane_r    <= lane_r + lane_width'(1);
                        end
                        if (last_s) begin
                            state_r <= LAST;
                        end
                    end
                end
                LAST: begin
                    state_r <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_result_packer.sv
// Bench for mxv_result_packer: two instances (8 lanes/10-bit address and 2 lanes/2-bit
// address) share all inputs; a cycle-level scoreboard plus literal expectations checks both.
module tb_mxv_result_packer;

    localparam int EW = 32;
    localparam int N0 = 8;
    localparam int A0 = 10;
    localparam int N1 = 2;
    localparam int A1 = 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [31:0]     total;
    logic [EW-1:0]   result_in;
    logic            result_valid;

    logic            a_mem_we, b_mem_we;
    logic [A0-1:0]   a_mem_addr;
    logic [A1-1:0]   b_mem_addr;
    logic [EW*N0-1:0] a_mem_wdata;
    logic [EW*N1-1:0] b_mem_wdata;
    logic            a_busy, b_busy, a_done, b_done;
    logic [31:0]     a_count, b_count;

    mxv_result_packer #(.element_width(EW), .no_of_units(N0), .addr_width(A0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .total(total),
        .result_in(result_in), .result_valid(result_valid),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .busy(a_busy), .done(a_done), .count(a_count));

    mxv_result_packer #(.element_width(EW), .no_of_units(N1), .addr_width(A1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .total(total),
        .result_in(result_in), .result_valid(result_valid),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .count(b_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int           due;
        int           addr;
        logic [255:0] data;
    } wr_t;

    wr_t q_a[$], q_b[$];       // expected writes
    wr_t log_a[$], log_b[$];   // observed writes
    int  vals_a[$], vals_b[$]; // results waiting to fill a word
    int  words_a, words_b;
    int  m_total = 0, m_acc = 0;
    bit  m_active = 1'b0;
    int  done_due = -1;
    int  busy_lo = 1, busy_hi = 0;
    int  cnt_val = 0, cnt_old = 0, cnt_from = 0;
    int  a_done_cyc = -1;

    function automatic logic [255:0] make_word(input int v[$]);
        logic [255:0] d;
        d = '0;
        foreach (v[i]) d[i*32 +: 32] = v[i];
        return d;
    endfunction

    task automatic set_cnt(input int v, input int c);
        cnt_old  = cnt_val;
        cnt_val  = v;
        cnt_from = c + 1;
    endtask

    task automatic model_start(input int t, input int c);
        if (c >= busy_lo && c <= busy_hi) return;
        m_total = t;
        m_acc   = 0;
        words_a = 0;
        words_b = 0;
        vals_a.delete();
        vals_b.delete();
        set_cnt(0, c);
        busy_lo = c + 1;
        if (t == 0) begin
            m_active = 1'b0;
            done_due = c + 1;
            busy_hi  = c + 1;
        end else begin
            m_active = 1'b1;
            busy_hi  = 1 << 30;
        end
    endtask

    task automatic model_valid(input int v, input int c);
        bit  last;
        wr_t w;
        if (!m_active) return;
        m_acc++;
        vals_a.push_back(v);
        vals_b.push_back(v);
        last = (m_acc == m_total);
        set_cnt(m_acc, c);
        if (vals_a.size() == N0 || last) begin
            w.due = c + 1; w.addr = words_a % (1 << A0); w.data = make_word(vals_a);
            q_a.push_back(w); words_a++; vals_a.delete();
        end
        if (vals_b.size() == N1 || last) begin
            w.due = c + 1; w.addr = words_b % (1 << A1); w.data = make_word(vals_b);
            q_b.push_back(w); words_b++; vals_b.delete();
        end
        if (last) begin
            m_active = 1'b0;
            done_due = c + 2;
            busy_hi  = c + 2;
        end
    endtask

    task automatic model_reset(input int c);
        m_active = 1'b0;
        vals_a.delete();
        vals_b.delete();
        while (q_a.size() > 0 && q_a[$].due > c) void'(q_a.pop_back());
        while (q_b.size() > 0 && q_b[$].due > c) void'(q_b.pop_back());
        if (done_due > c) done_due = -1;
        if (busy_hi > c) busy_hi = c;
        set_cnt(0, c);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit  exp_busy, ew;
            int  exp_cnt;
            wr_t w;
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            exp_cnt  = (cyc >= cnt_from) ? cnt_val : cnt_old;
            check("a_busy", a_busy, exp_busy);
            check("b_busy", b_busy, exp_busy);
            check("a_done", a_done, done_due == cyc);
            check("b_done", b_done, done_due == cyc);
            check("a_count", a_count, exp_cnt);
            check("b_count", b_count, exp_cnt);
            if (a_done) a_done_cyc = cyc;

            while (q_a.size() > 0 && q_a[0].due < cyc) void'(q_a.pop_front());
            ew = (q_a.size() > 0) && (q_a[0].due == cyc);
            check("a_mem_we", a_mem_we, ew);
            if (ew) begin
                check("a_mem_addr", a_mem_addr, q_a[0].addr);
                check("a_mem_wdata", a_mem_wdata, q_a[0].data);
                void'(q_a.pop_front());
            end
            if (a_mem_we) begin
                w.due = cyc; w.addr = a_mem_addr; w.data = a_mem_wdata; log_a.push_back(w);
            end

            while (q_b.size() > 0 && q_b[0].due < cyc) void'(q_b.pop_front());
            ew = (q_b.size() > 0) && (q_b[0].due == cyc);
            check("b_mem_we", b_mem_we, ew);
            if (ew) begin
                check("b_mem_addr", b_mem_addr, q_b[0].addr);
                check("b_mem_wdata", b_mem_wdata, q_b[0].data);
                void'(q_b.pop_front());
            end
            if (b_mem_we) begin
                w.due = cyc; w.addr = b_mem_addr; w.data = b_mem_wdata; log_b.push_back(w);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk);
        #1;
        start = 1'b0;
        result_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic do_start(input int t);
        step;
        start = 1'b1;
        total = t;
        model_start(t, cyc);
    endtask

    task automatic do_valid(input int v);
        step;
        result_valid = 1'b1;
        result_in = v;
        model_valid(v, cyc);
    endtask

    task automatic do_reset;
        step;
        reset = 1'b1;
        model_reset(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) step;
    endtask

    task automatic clear_logs;
        log_a.delete();
        log_b.delete();
    endtask

    int v_last, s_cyc;
    int exp_addr[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; start = 1'b0; total = 32'd0; result_in = '0; result_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_a_addr", a_mem_addr, 0);
        check("rst_a_wdata", a_mem_wdata, 0);
        check("rst_b_wdata", b_mem_wdata, 0);

        // Full words back-to-back
        clear_logs();
        do_start(16);
        for (int i = 1; i <= 16; i++) do_valid(i);
        idle(4);
        check("t1_nwrites", log_a.size(), 2);
        if (log_a.size() >= 2) begin
            check("t1_addr0", log_a[0].addr, 0);
            check("t1_word0", log_a[0].data, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
            check("t1_addr1", log_a[1].addr, 1);
            check("t1_word1", log_a[1].data, {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9});
            check("t1_done_time", a_done_cyc, log_a[1].due + 1);
        end
        check("t1_count", a_count, 16);

        // Partial last word
        clear_logs();
        do_start(10);
        for (int i = 1; i <= 10; i++) do_valid(i);
        v_last = cyc;
        idle(4);
        check("t2_nwrites", log_a.size(), 2);
        if (log_a.size() >= 2) begin
            check("t2_addr1", log_a[1].addr, 1);
            check("t2_word1", log_a[1].data, {192'd0, 32'd10, 32'd9});
        end
        check("t2_done_time", a_done_cyc, v_last + 2);

        // Gapped input, then excess results after done
        clear_logs();
        do_start(8);
        for (int i = 1; i <= 8; i++) begin
            do_valid(20 + i);
            idle(3);
        end
        idle(2);
        for (int i = 0; i < 4; i++) do_valid(99);
        idle(3);
        check("t3_nwrites", log_a.size(), 1);
        if (log_a.size() >= 1) check("t3_addr0", log_a[0].addr, 0);
        check("t3_count", a_count, 8);

        // total==0, then a start ignored mid-run
        clear_logs();
        do_start(0);
        s_cyc = cyc;
        idle(3);
        check("t4_zero_done", a_done_cyc, s_cyc + 1);
        check("t4_zero_nwr_a", log_a.size(), 0);
        check("t4_zero_nwr_b", log_b.size(), 0);
        do_start(8);
        for (int i = 1; i <= 3; i++) do_valid(40 + i);
        do_start(16);
        for (int i = 4; i <= 8; i++) do_valid(40 + i);
        idle(4);
        check("t4_count", a_count, 8);
        check("t4_nwrites", log_a.size(), 1);

        // Reset mid-run
        clear_logs();
        do_start(16);
        for (int i = 1; i <= 5; i++) do_valid(60 + i);
        do_reset;
        step;
        check("t5_b_addr", b_mem_addr, 0);
        check("t5_b_wdata", b_mem_wdata, 0);
        check("t5_a_count", a_count, 0);
        check("t5_a_busy", a_busy, 0);
        idle(2);
        clear_logs();
        do_start(8);
        for (int i = 1; i <= 8; i++) do_valid(100 + i);
        idle(4);
        check("t5_nwrites", log_a.size(), 1);
        if (log_a.size() >= 1) check("t5_addr0", log_a[0].addr, 0);

        // Address wrap on the narrow instance
        clear_logs();
        do_start(10);
        for (int i = 1; i <= 10; i++) do_valid(i);
        idle(4);
        check("t6_nwrites", log_b.size(), 5);
        if (log_b.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("t6_addr", log_b[i].addr, exp_addr[i]);
            check("t6_last_word", log_b[4].data, {32'd10, 32'd9});
        end

        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
